// File: rtl/alu_pkg.sv
// Shared ALU control encodings, RV32I opcode/funct3 constants and the
// round-robin pick helper used by the ALU arbiter.
package alu_pkg;

    localparam int ALU_CTL_WIDTH = 4;
    localparam int RR_MAX        = 8;

    typedef enum logic [ALU_CTL_WIDTH-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_SEQ   = 4'd10,
        ALU_SNE   = 4'd11,
        ALU_SGE   = 4'd12,
        ALU_SGEU  = 4'd13,
        ALU_AUIPC = 4'd14
    } alu_op_e;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // First valid index after 'last', wrapping modulo n.
    function automatic logic [2:0] rr_pick(
        input logic [7:0]  valid,
        input logic [2:0]  last,
        input int unsigned n
    );
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX; i++) begin
            idx = (32'(last) + i) % n;
            if (!found && i <= n && valid[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response bundle of the ALU arbiter.
// slave: arbiter side; master: requesters, ALU and consumer side.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    import alu_pkg::*;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*7-1:0]    req_opcode;
    logic [NUM_REQ*3-1:0]    req_funct3;
    logic [NUM_REQ*7-1:0]    req_funct7;
    logic [NUM_REQ*XLEN-1:0] req_a;
    logic [NUM_REQ*XLEN-1:0] req_b;

    logic [ALU_CTL_WIDTH-1:0] alu_ctl;
    logic [XLEN-1:0]          alu_a;
    logic [XLEN-1:0]          alu_b;
    logic [XLEN-1:0]          alu_result;

    logic            resp_valid;
    logic            resp_ready;
    logic [ID_W-1:0] resp_id;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_funct7,
        input  req_a, req_b, alu_result, resp_ready,
        output req_ready, alu_ctl, alu_a, alu_b,
        output resp_valid, resp_id, resp_data, resp_err
    );

    modport master (
        output req_valid, req_opcode, req_funct3, req_funct7,
        output req_a, req_b, alu_result, resp_ready,
        input  req_ready, alu_ctl, alu_a, alu_b,
        input  resp_valid, resp_id, resp_data, resp_err
    );

endinterface

// File: rtl/alu_decoder.sv
// RV32I opcode/funct3/funct7 to ALU control word decoder.
// Ports: opcode_i, funct3_i, funct7_i in; ctl_o control, err_o illegal.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output alu_op_e    ctl_o,
    output logic       err_o
);

    always_comb begin
        ctl_o = ALU_ADD;
        err_o = 1'b0;
        unique case (1'b1)
            (opcode_i == OPC_LOAD),
            (opcode_i == OPC_STORE):  ctl_o = ALU_ADD;
            (opcode_i == OPC_AUIPC):  ctl_o = ALU_AUIPC;
            (opcode_i == OPC_BRANCH): begin
                case (funct3_i)
                    F3_BEQ:  ctl_o = ALU_SEQ;
                    F3_BNE:  ctl_o = ALU_SNE;
                    F3_BLT:  ctl_o = ALU_SLT;
                    F3_BGE:  ctl_o = ALU_SGE;
                    F3_BLTU: ctl_o = ALU_SLTU;
                    F3_BGEU: ctl_o = ALU_SGEU;
                    default: err_o = 1'b1;
                endcase
            end
            (opcode_i == OPC_OP),
            (opcode_i == OPC_OP_IMM): begin
                case (funct3_i)
                    // Immediate forms have no SUB; bit 5 there is imm.
                    F3_ADD:  ctl_o = (opcode_i == OPC_OP && funct7_i[5])
                                   ? ALU_SUB : ALU_ADD;
                    F3_SLL:  ctl_o = ALU_SLL;
                    F3_SLT:  ctl_o = ALU_SLT;
                    F3_SLTU: ctl_o = ALU_SLTU;
                    F3_XOR:  ctl_o = ALU_XOR;
                    F3_SR:   ctl_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:   ctl_o = ALU_OR;
                    default: ctl_o = ALU_AND;
                endcase
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters, with a
// single-entry tagged response buffer. Ports: clk, rst_n, bus (slave).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    buf_state_e      state_q, state_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;

    logic               can_accept;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    sel;
    alu_op_e            dec_ctl;
    logic               dec_err;

    // A full buffer can take a new entry only if it drains this edge.
    assign can_accept = (state_q == BUF_EMPTY) || bus.resp_ready;
    assign gnt_any    = can_accept && (|bus.req_valid);
    assign gnt_idx    = ID_W'(rr_pick(8'(bus.req_valid), 3'(last_q),
                                      NUM_REQ));
    // Idle falls back to requester 0 so the ALU never sees X.
    assign sel        = gnt_any ? gnt_idx : '0;

    assign bus.req_ready = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign bus.alu_a     = bus.req_a[sel*XLEN +: XLEN];
    assign bus.alu_b     = bus.req_b[sel*XLEN +: XLEN];
    assign bus.alu_ctl   = dec_ctl;

    alu_decoder u_dec (
        .opcode_i (bus.req_opcode[sel*7 +: 7]),
        .funct3_i (bus.req_funct3[sel*3 +: 3]),
        .funct7_i (bus.req_funct7[sel*7 +: 7]),
        .ctl_o    (dec_ctl),
        .err_o    (dec_err)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            BUF_EMPTY: if (gnt_any) state_d = BUF_FULL;
            BUF_FULL: begin
                if (bus.resp_ready && !gnt_any) state_d = BUF_EMPTY;
            end
            default: state_d = BUF_EMPTY;
        endcase
        if (gnt_any) begin
            id_d   = sel;
            last_d = sel;
            err_d  = dec_err;
            data_d = dec_err ? '0 : bus.alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            last_q  <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.resp_valid = (state_q == BUF_FULL);
    assign bus.resp_id    = id_q;
    assign bus.resp_data  = data_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural ALU.
// Stimulus pushes expected responses; a monitor pops on each transfer.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NR = 2;
    localparam int XL = 32;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    alu_arbiter_if #(.NUM_REQ(NR), .XLEN(XL)) bus ();

    alu_arbiter #(.NUM_REQ(NR), .XLEN(XL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_ctl)
            ALU_ADD, ALU_AUIPC: bus.alu_result = bus.alu_a + bus.alu_b;
            ALU_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
            ALU_SLL:  bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            ALU_SRL:  bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            ALU_SRA:  bus.alu_result =
                          $signed(bus.alu_a) >>> bus.alu_b[4:0];
            ALU_SLT:  bus.alu_result =
                          {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            ALU_SLTU: bus.alu_result = {31'b0, bus.alu_a < bus.alu_b};
            ALU_SGE:  bus.alu_result =
                          {31'b0, $signed(bus.alu_a) >= $signed(bus.alu_b)};
            ALU_SGEU: bus.alu_result = {31'b0, bus.alu_a >= bus.alu_b};
            ALU_SEQ:  bus.alu_result = {31'b0, bus.alu_a == bus.alu_b};
            ALU_SNE:  bus.alu_result = {31'b0, bus.alu_a != bus.alu_b};
            ALU_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
            ALU_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
            ALU_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
            default:  bus.alu_result = '0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v,
                           input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a,
                           input logic [31:0] b);
        bus.req_valid[i]          = v;
        bus.req_opcode[i*7 +: 7]  = op;
        bus.req_funct3[i*3 +: 3]  = f3;
        bus.req_funct7[i*7 +: 7]  = f7;
        bus.req_a[i*XL +: XL]     = a;
        bus.req_b[i*XL +: XL]     = b;
    endtask

    task automatic push(input int id, input logic [31:0] d, input logic e);
        exp_t x;
        x.id   = id;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: got id %0d data %0h, none expected",
                         bus.resp_id, bus.resp_data);
            end else begin
                e = sb.pop_front();
                check("resp_id", 64'(bus.resp_id), 64'(e.id));
                check("resp_data", 64'(bus.resp_data), 64'(e.data));
                check("resp_err", 64'(bus.resp_err), 64'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_funct3 = '0;
        bus.req_funct7 = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_resp_valid", 64'(bus.resp_valid), 0);
        check("rst_resp_id", 64'(bus.resp_id), 0);
        check("rst_resp_data", 64'(bus.resp_data), 0);
        check("rst_resp_err", 64'(bus.resp_err), 0);
        check("rst_req_ready", 64'(bus.req_ready), 0);
        tick();
        rst_n = 1'b1;

        // Round-robin: 0 ADD 1+1, 1 AND F0&3C
        set_req(0, 1, OPC_OP, F3_ADD, 7'h00, 32'd1, 32'd1);
        set_req(1, 1, OPC_OP, F3_AND, 7'h00, 32'hF0, 32'h3C);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_ready", 64'(bus.req_ready), (k % 2 == 0) ? 1 : 2);
            if (k % 2 == 0) push(0, 32'd2, 1'b0);
            else push(1, 32'h30, 1'b0);
            tick();
        end
        bus.req_valid = '0;
        @(negedge clk);
        check("rr_tail_valid", 64'(bus.resp_valid), 1);
        tick();

        // Single SUB 10-3 from requester 0
        set_req(0, 1, OPC_OP, F3_ADD, 7'h20, 32'd10, 32'd3);
        @(negedge clk);
        check("sub_ready", 64'(bus.req_ready), 1);
        check("sub_ctl", 64'(bus.alu_ctl), 64'(ALU_SUB));
        push(0, 32'd7, 1'b0);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("sub_resp_valid", 64'(bus.resp_valid), 1);
        tick();

        // Backpressure
        set_req(0, 1, OPC_OP_IMM, F3_ADD, 7'h20, 32'd5, 32'd6);
        @(negedge clk);
        check("bp_first_ready", 64'(bus.req_ready), 1);
        push(0, 32'd11, 1'b0);
        tick();
        bus.resp_ready = 1'b0;
        bus.req_valid  = '0;
        set_req(1, 1, OPC_OP, F3_XOR, 7'h00, 32'hFF, 32'h0F);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_ready", 64'(bus.req_ready), 0);
            check("bp_valid", 64'(bus.resp_valid), 1);
            check("bp_data", 64'(bus.resp_data), 11);
            check("bp_id", 64'(bus.resp_id), 0);
            tick();
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(bus.req_ready), 2);
        push(1, 32'hF0, 1'b0);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("bp_reload_valid", 64'(bus.resp_valid), 1);
        tick();
        @(negedge clk);
        check("bp_drained", 64'(bus.resp_valid), 0);
        tick();

        // Illegal opcode
        set_req(0, 1, 7'h7F, 3'b000, 7'h00, 32'd5, 32'd6);
        @(negedge clk);
        check("ill_ready", 64'(bus.req_ready), 1);
        check("ill_ctl", 64'(bus.alu_ctl), 64'(ALU_ADD));
        push(0, 32'd0, 1'b1);
        tick();
        bus.req_valid = '0;

        // Branch BGE -1 >= 0
        set_req(1, 1, OPC_BRANCH, F3_BGE, 7'h00, 32'hFFFF_FFFF, 32'd0);
        @(negedge clk);
        check("bge_ready", 64'(bus.req_ready), 2);
        check("bge_ctl", 64'(bus.alu_ctl), 64'(ALU_SGE));
        push(1, 32'd0, 1'b0);
        tick();
        bus.req_valid = '0;
        tick();

        // Reset mid-stall
        bus.resp_ready = 1'b0;
        set_req(1, 1, OPC_OP, F3_ADD, 7'h00, 32'd2, 32'd3);
        @(negedge clk);
        check("rs_ready", 64'(bus.req_ready), 2);
        push(1, 32'd5, 1'b0);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("rs_full", 64'(bus.resp_valid), 1);
        check("rs_data", 64'(bus.resp_data), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async_valid", 64'(bus.resp_valid), 0);
        check("rs_async_data", 64'(bus.resp_data), 0);
        sb.delete();
        tick();
        rst_n          = 1'b1;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rs_no_pulse", 64'(bus.resp_valid), 0);
            tick();
        end
        set_req(0, 1, OPC_OP, F3_ADD, 7'h00, 32'd7, 32'd8);
        set_req(1, 1, OPC_OP, F3_ADD, 7'h00, 32'd1, 32'd1);
        @(negedge clk);
        check("rs_first_ready", 64'(bus.req_ready), 1);
        push(0, 32'd15, 1'b0);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("rs_resp_valid", 64'(bus.resp_valid), 1);
        tick();
        @(negedge clk);
        check("end_idle", 64'(bus.resp_valid), 0);
        check("sb_left", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU datapath between NUM_REQ requesters, e.g. the execute stage and the branch/address unit.
- Each cycle it picks one valid request round-robin, decodes its opcode/funct3/funct7 into an ALU control word and drives the shared ALU operands.
- It registers the ALU result into a single-entry response buffer, tagged with the requester index.
- The response is held until the consumer accepts it.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- XLEN, 32, operand/result width.
- ID_W, $clog2(NUM_REQ) (minimum 1), width of the response requester tag.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_opcode  in  NUM_REQ*7  packed opcodes, requester i at [7i+:7].
- req_funct3  in  NUM_REQ*3  packed funct3.
- req_funct7  in  NUM_REQ*7  packed funct7.
- req_a  in  NUM_REQ*XLEN  packed operand A.
- req_b  in  NUM_REQ*XLEN  packed operand B.
- alu_ctl  out  ALU_CTL_WIDTH  control word to the shared ALU.
- alu_a  out  XLEN  operand A to the shared ALU.
- alu_b  out  XLEN  operand B to the shared ALU.
- alu_result  in  XLEN  combinational result from the shared ALU.
- resp_valid  out  1  response buffer occupied.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_data  out  XLEN  registered ALU result.
- resp_err  out  1  request had an opcode outside LOAD/STORE/AUIPC/BRANCH/OP/OP_IMM.

Behaviour:
- Reset (async, rst_n=0):
  - resp_valid=0, resp_id=0, resp_data=0, resp_err=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 wins first.
  - req_ready is combinational and is therefore 0 while resp_valid=0 and no req_valid is set.
- Buffer states:
  - EMPTY (resp_valid=0) and FULL (resp_valid=1).
  - can_accept = EMPTY or (FULL and resp_ready).
- Arbitration (combinational):
  - If can_accept and any req_valid, grant the first valid index scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
  - req_ready[g]=1 for the granted index only.
  - No grant when can_accept=0; all req_ready are 0.
- ALU drive:
  - alu_a/alu_b/alu_ctl are taken from the granted requester.
  - When there is no grant, they are taken from requester 0; these values are don't-care but must not be X-propagating.
  - alu_ctl is decoded per the standard RV32I mapping: LOAD/STORE→ADD, AUIPC→AUIPC, BRANCH funct3→SEQ/SNE/SLT/SGE/SLTU/SGEU, OP/OP_IMM funct3→ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - SUB only for OP with funct7[5]=1; SRA when funct7[5]=1.
  - Unknown opcode or branch funct3 → alu_ctl=ALU_ADD and err=1.
- Handshake timing:
  - A transfer occurs on the rising edge where req_valid[i] & req_ready[i].
  - At that edge: resp_data←alu_result, resp_id←i, resp_err←err, resp_valid←1, last_grant←i.
  - If err=1, resp_data is loaded with 0.
- Latency and throughput:
  - Latency is 1 cycle from accept to resp_valid.
  - Throughput is 1 request/cycle while resp_ready=1.
- Simultaneous pop and push: when FULL with resp_ready=1 and a grant, the buffer reloads in the same edge and resp_valid stays 1.
- Pop only: when FULL with resp_ready=1 and no grant, resp_valid←0 at the edge.
- Stall:
  - When FULL with resp_ready=0, resp_* hold stable and req_ready=0.
  - Requesters must hold req_valid and their payload stable until accepted. The block does not latch inputs before acceptance.
- Fairness: with all requesters continuously valid and resp_ready=1, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Reset mid-operation: any buffered response is discarded, and no resp_valid pulse is produced after rst_n rises until a new request is accepted.

Decomposition:
- The shared package alu_pkg holds:
  - ALU_CTL_WIDTH and the ALU_* control encodings, taken from alu_defs.sv.
  - The RV32 opcode/funct3 constants, taken from rv32i_defs.sv.
  - A function rr_pick(valid, last) returning the next grant index.
- One sub-module: alu_decoder, instantiated once on the muxed opcode/funct3/funct7.
  - Its default branches are extended to drive ALU_ADD plus an err output instead of simulation-only messages.

Test Plan:
- Single request: after reset, req_valid=01, opcode=OP, funct3=000, funct7=0x20, A=10, B=3, ALU model → req_ready=01 same cycle; next cycle resp_valid=1, resp_id=0, resp_data=7, resp_err=0.
- Round-robin:
  - Both valid for 4 cycles, resp_ready=1, requester 0 ADD 1+1, requester 1 AND 0xF0&0x3C.
  - Grants are 0,1,0,1 and resp_id is 0,1,0,1.
  - resp_data alternates 2, 0x30.
- Backpressure:
  - resp_ready=0 after the first response → req_ready=00 and resp_* hold for 5 cycles.
  - Raising resp_ready pops the held response and accepts the next request in the same cycle; resp_valid stays 1.
- Illegal opcode: opcode=0x7F → accepted; resp_err=1, resp_data=0, alu_ctl=ALU_ADD during the grant.
- Branch decode: BRANCH funct3=101 (BGE), A=-1, B=0 → alu_ctl=ALU_SGE; resp_data=0.
- Reset mid-stall: FULL with resp_ready=0, assert rst_n=0 asynchronously mid-cycle → resp_valid=0 immediately. After release, requester 0 wins first even if requester 1 was granted last.
